imm_ext_arbiter: RTL and testbench
==================================

// Module: imm_ext_arbiter
// PURPOSE
//  Shares the single SignExtender between two requesters (0: decode, 1: branch-target unit).
//  Accepts a 32-bit LEGv8 instruction per request and decodes instr[31:21] to the extender Ctrl.
//  Drives the shared extender with instr[25:0] and registers BusImm into a response.
//  Serves one request at a time with round-robin grant and valid/ready handshakes.
// PARAMETERS
//  IMM_W   26  immediate field width driven to the extender (instr[IMM_W-1:0])
//  DATA_W  64  extended immediate width returned by the extender
// PORTS
//  CLK         in   1       clock, all state updates on rising edge
//  resetl      in   1       synchronous, active-low reset
//  req_valid   in   2       per-requester request valid
//  req_instr0  in   32      requester 0 instruction
//  req_instr1  in   32      requester 1 instruction
//  req_ready   out  2       one-hot accept; transfer when req_valid[i] & req_ready[i]
//  ext_imm     out  IMM_W   to shared SignExtender Imm
//  ext_ctrl    out  2       to shared SignExtender Ctrl
//  ext_busimm  in   DATA_W  from shared SignExtender BusImm (combinational)
//  rsp_valid   out  1       response valid
//  rsp_ready   in   1       response consumer ready
//  rsp_id      out  1       requester index of response
//  rsp_imm     out  DATA_W  extended immediate
//  rsp_err     out  1       opcode matched no immediate format; rsp_imm = 0
// BEHAVIOUR
//  Reset (resetl=0 at edge): state=IDLE, last_grant=1, req_ready=0, rsp_valid=0, rsp_id=0,
//   rsp_imm=0, rsp_err=0, ext_imm=0, ext_ctrl=2'b00. Reset mid-operation drops any held request/response.
//  Opcode decode (op = instr[31:21]), first match wins:
//   op[10:5]=000101 -> B, ctrl 10 | op[10:3]=10110100 -> CBZ, ctrl 11
//   op=11111000010 (LDUR) or 11111000000 (STUR) -> D, ctrl 01
//   op[10:1] in {1001000100,1101000100,1011001000,1001001000} (ADDI/SUBI/ORRI/ANDI) -> I, ctrl 00
//   otherwise illegal: err=1, ctrl 00.
//  FSM:
//   IDLE: req_ready combinational. One valid -> grant it. Both valid -> grant ~last_grant.
//         On grant: latch instr, id, ctrl, err; last_grant<=id; ->EXT. No valid: stay, req_ready=0.
//   EXT:  ext_imm=latched instr[25:0], ext_ctrl=latched ctrl; at edge rsp_imm<=err?0:ext_busimm,
//         rsp_id, rsp_err latched; ->RESP. req_ready=0.
//   RESP: rsp_valid=1; rsp_* stable while rsp_ready=0. rsp_ready=1 -> IDLE at edge.
//  ext_imm/ext_ctrl hold last driven value outside EXT (no toggling when idle).
//  Latency: accept edge N, rsp_valid high from cycle N+2; min 3 cycles per request (no back-to-back).
//  req_ready only asserted in IDLE, never to both; never asserted for a requester with req_valid=0.
//  Requester may drop req_valid before grant; no request is latched without handshake.
//  Fairness: continuously valid requesters alternate grants 0,1,0,1...
//  Stalled response (rsp_ready=0 indefinitely) blocks all grants; no buffering beyond one response.
// TESTING
//  Reset then req0 ADDI instr 0x9103FC41 (imm12=0x0FF), rsp_ready=1 -> req_ready=01 at accept,
//   rsp_valid 2 cycles later, rsp_id=0, rsp_imm=0x00000000000000FF, rsp_err=0.
//  req1 B instr 0x17FFFFFF (imm26=-1) -> ext_ctrl=10 in EXT, rsp_imm=0xFFFFFFFFFFFFFFFC, rsp_id=1.
//  Both valid every cycle, req0 CBZ 0xB4000020 (imm19=1), req1 LDUR 0xF85F0000 (imm9=-16) ->
//   grant order 0,1,0,1; responses alternate 0x4 / 0xFFFFFFFFFFFFFFF0.
//  Illegal opcode 0x00000000 -> rsp_err=1, rsp_imm=0; next legal request unaffected.
//  rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=00, no new grant until rsp_ready=1.
//  resetl=0 during EXT and during RESP -> next cycle rsp_valid=0, state IDLE, req0 wins next contest.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one SignExtender between decode (0) and branch-target (1).
// Decodes the LEGv8 opcode to the extender Ctrl and returns the registered extended immediate.
module imm_ext_arbiter #(
    parameter int unsigned IMM_W  = 26,
    parameter int unsigned DATA_W = 64
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [1:0]        req_valid,
    input  logic [31:0]       req_instr0,
    input  logic [31:0]       req_instr1,
    output logic [1:0]        req_ready,
    output logic [IMM_W-1:0]  ext_imm,
    output logic [1:0]        ext_ctrl,
    input  logic [DATA_W-1:0] ext_busimm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_imm,
    output logic              rsp_err
);

    localparam int unsigned OP_W   = 11;
    localparam int unsigned OP_LSB = 21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               id_q, id_d;
    logic               err_q, err_d;
    logic [IMM_W-1:0]   ext_imm_q, ext_imm_d;
    logic [1:0]         ext_ctrl_q, ext_ctrl_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_imm_q, rsp_imm_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant_id_c;
    logic [31:0]        sel_instr_c;
    logic [2:0]         dec_c;

    // Returns {err, ctrl}; earlier formats take priority.
    function automatic logic [2:0] decode_op(input logic [OP_W-1:0] op);
        logic [2:0] r;
        r = 3'b100;
        if (op[10:5] == 6'b000101) begin
            r = 3'b010;
        end else if (op[10:3] == 8'b10110100) begin
            r = 3'b011;
        end else if (op == 11'b11111000010 || op == 11'b11111000000) begin
            r = 3'b001;
        end else if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100 ||
                     op[10:1] == 10'b1011001000 || op[10:1] == 10'b1001001000) begin
            r = 3'b000;
        end
        return r;
    endfunction

    always_comb begin
        grant_id_c = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id_c = ~last_grant_q;
        end else if (req_valid[1]) begin
            grant_id_c = 1'b1;
        end
        sel_instr_c = grant_id_c ? req_instr1 : req_instr0;
        dec_c       = decode_op(sel_instr_c[OP_LSB +: OP_W]);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        err_d        = err_q;
        ext_imm_d    = ext_imm_q;
        ext_ctrl_d   = ext_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_imm_d    = rsp_imm_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready    = grant_id_c ? 2'b10 : 2'b01;
                    ext_imm_d    = sel_instr_c[IMM_W-1:0];
                    ext_ctrl_d   = dec_c[1:0];
                    err_d        = dec_c[2];
                    id_d         = grant_id_c;
                    last_grant_d = grant_id_c;
                    state_d      = ST_EXT;
                end
            end
            ST_EXT: begin
                // Extender inputs were loaded at grant, so BusImm is settled here.
                rsp_imm_d   = err_q ? '0 : ext_busimm;
                rsp_id_d    = id_q;
                rsp_err_d   = err_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            ext_imm_q    <= '0;
            ext_ctrl_q   <= 2'b00;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_imm_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            err_q        <= err_d;
            ext_imm_q    <= ext_imm_d;
            ext_ctrl_q   <= ext_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_imm_q    <= rsp_imm_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign ext_imm   = ext_imm_q;
    assign ext_ctrl  = ext_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_imm   = rsp_imm_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter with a behavioural LEGv8 SignExtender on the shared port.
module tb_imm_ext_arbiter;

    localparam logic [31:0] I_ADDI = 32'h9103FC41;
    localparam logic [31:0] I_B    = 32'h17FFFFFF;
    localparam logic [31:0] I_CBZ  = 32'hB4000020;
    localparam logic [31:0] I_LDUR = 32'hF85F0000;
    localparam logic [31:0] I_ILL  = 32'h00000000;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [1:0]  req_valid;
    logic [31:0] req_instr0;
    logic [31:0] req_instr1;
    logic [1:0]  req_ready;
    logic [25:0] ext_imm;
    logic [1:0]  ext_ctrl;
    logic [63:0] ext_busimm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [63:0] rsp_imm;
    logic        rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    imm_ext_arbiter #(.IMM_W(26), .DATA_W(64)) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .req_valid  (req_valid),
        .req_instr0 (req_instr0),
        .req_instr1 (req_instr1),
        .req_ready  (req_ready),
        .ext_imm    (ext_imm),
        .ext_ctrl   (ext_ctrl),
        .ext_busimm (ext_busimm),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_imm    (rsp_imm),
        .rsp_err    (rsp_err)
    );

    always #5 CLK = ~CLK;

    // Shared SignExtender: I zero-extends imm12, D/B/CBZ sign-extend (branches scaled by 4).
    always_comb begin
        case (ext_ctrl)
            2'b00:   ext_busimm = {52'b0, ext_imm[21:10]};
            2'b01:   ext_busimm = {{55{ext_imm[20]}}, ext_imm[20:12]};
            2'b10:   ext_busimm = {{36{ext_imm[25]}}, ext_imm[25:0], 2'b00};
            default: ext_busimm = {{43{ext_imm[23]}}, ext_imm[23:5], 2'b00};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One isolated request from IDLE through a completed response.
    task automatic single(input int id, input logic [31:0] instr, input logic [1:0] exp_ctrl,
                          input logic [63:0] exp_imm, input logic exp_err);
        if (id == 0) begin
            req_instr0 = instr;
            req_valid  = 2'b01;
        end else begin
            req_instr1 = instr;
            req_valid  = 2'b10;
        end
        #1;
        check("single_ready", 64'(req_ready), (id == 0) ? 64'h1 : 64'h2);
        tick();
        req_valid = 2'b00;
        check("single_ext_ctrl", 64'(ext_ctrl), 64'(exp_ctrl));
        check("single_ext_imm", 64'(ext_imm), 64'(instr[25:0]));
        check("single_no_early_rsp", 64'(rsp_valid), 64'h0);
        tick();
        check("single_rsp_valid", 64'(rsp_valid), 64'h1);
        check("single_rsp_id", 64'(rsp_id), 64'(id));
        check("single_rsp_imm", rsp_imm, exp_imm);
        check("single_rsp_err", 64'(rsp_err), 64'(exp_err));
        tick();
        check("single_rsp_done", 64'(rsp_valid), 64'h0);
    endtask

    initial begin
        resetl     = 1'b0;
        req_valid  = 2'b00;
        req_instr0 = '0;
        req_instr1 = '0;
        rsp_ready  = 1'b1;
        tick();
        tick();
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'h0);
        check("rst_rsp_imm", rsp_imm, 64'h0);
        check("rst_rsp_err", 64'(rsp_err), 64'h0);
        check("rst_ext_imm", 64'(ext_imm), 64'h0);
        check("rst_ext_ctrl", 64'(ext_ctrl), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        resetl = 1'b1;
        tick();
        check("idle_no_valid_ready", 64'(req_ready), 64'h0);

        single(0, I_ADDI, 2'b00, 64'h00000000000000FF, 1'b0);
        single(1, I_B, 2'b10, 64'hFFFFFFFFFFFFFFFC, 1'b0);

        // Both requesters continuously valid: grants alternate starting with 0.
        req_instr0 = I_CBZ;
        req_instr1 = I_LDUR;
        req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("fair_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            check("fair_ext_ctrl", 64'(ext_ctrl), (k % 2 == 0) ? 64'h3 : 64'h1);
            check("fair_ready_ext", 64'(req_ready), 64'h0);
            tick();
            check("fair_rsp_valid", 64'(rsp_valid), 64'h1);
            check("fair_rsp_id", 64'(rsp_id), 64'(k % 2));
            check("fair_rsp_imm", rsp_imm,
                  (k % 2 == 0) ? 64'h0000000000000004 : 64'hFFFFFFFFFFFFFFF0);
            check("fair_ready_resp", 64'(req_ready), 64'h0);
            tick();
        end
        req_valid = 2'b00;

        single(0, I_ILL, 2'b00, 64'h0, 1'b1);
        single(0, I_ADDI, 2'b00, 64'h00000000000000FF, 1'b0);

        // Stalled response holds everything and blocks new grants.
        req_instr0 = I_ADDI;
        req_instr1 = I_B;
        req_valid  = 2'b01;
        #1;
        check("stall_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_rsp_valid", 64'(rsp_valid), 64'h1);
            check("stall_rsp_imm", rsp_imm, 64'h00000000000000FF);
            check("stall_rsp_id", 64'(rsp_id), 64'h0);
            check("stall_req_ready", 64'(req_ready), 64'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("stall_release_valid", 64'(rsp_valid), 64'h0);
        check("stall_release_grant", 64'(req_ready), 64'h2);
        req_valid = 2'b00;
        #1;

        // Reset while in EXT: the held request is dropped and req0 wins the next contest.
        req_valid = 2'b10;
        #1;
        check("rst_ext_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 2'b00;
        resetl    = 1'b0;
        tick();
        resetl = 1'b1;
        check("rst_ext_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_ext_ctrl_clr", 64'(ext_ctrl), 64'h0);
        req_valid = 2'b11;
        #1;
        check("rst_ext_next_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        tick();
        check("rst_resp_pre_valid", 64'(rsp_valid), 64'h1);
        resetl = 1'b0;
        tick();
        resetl = 1'b1;
        check("rst_resp_valid", 64'(rsp_valid), 64'h0);
        check("rst_resp_imm", rsp_imm, 64'h0);
        req_valid = 2'b11;
        #1;
        check("rst_resp_next_grant", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b00;
        tick();
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'h1);
        check("post_rst_rsp_id", 64'(rsp_id), 64'h0);
        check("post_rst_rsp_imm", rsp_imm, 64'h00000000000000FF);
        tick();
        check("post_rst_done", 64'(rsp_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
